// File: rtl/seg_counter_pkg.sv
// Shared types and helpers for the segmented counter/comparator.
package seg_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Widest count the masked-equality helper accepts.
  localparam int unsigned MAX_W = 64;

  function automatic int unsigned calc_w(input int unsigned digit_w,
                                         input int unsigned num_digits);
    return digit_w * num_digits;
  endfunction

  // True when every bit selected by m matches between a and b.
  function automatic logic masked_eq(input logic [MAX_W-1:0] a,
                                     input logic [MAX_W-1:0] b,
                                     input logic [MAX_W-1:0] m);
    return &(~(a ^ b) | ~m);
  endfunction

endpackage

// File: rtl/seg_digit.sv
// One digit stage of the cascaded counter: holds its own digit, steps when the
// carry-in enable is set, and passes enable upward when at its roll value.
module seg_digit
  import seg_counter_pkg::*;
#(
  parameter int unsigned DIGIT_W = 4
) (
  input  logic               CK,
  input  logic               RN,
  input  logic               i_cen,
  input  dir_e               i_dir,
  input  logic               i_ld,
  input  logic [DIGIT_W-1:0] i_ld_val,
  input  logic               i_force,
  input  logic [DIGIT_W-1:0] i_force_val,
  output logic [DIGIT_W-1:0] o_q,
  output logic [DIGIT_W-1:0] o_q_next,
  output logic               o_cout
);

  logic [DIGIT_W-1:0] r_q;
  logic [DIGIT_W-1:0] w_next;
  logic               w_roll;

  // Next digit value (load > force > step > hold) and carry to the next stage.
  always_comb begin
    w_roll = (i_dir == DIR_UP) ? (r_q == '1) : (r_q == '0);
    o_cout = i_cen & w_roll;
    w_next = r_q;
    if (i_ld) begin
      w_next = i_ld_val;
    end else if (i_force) begin
      w_next = i_force_val;
    end else if (i_cen) begin
      w_next = (i_dir == DIR_UP) ? r_q + DIGIT_W'(1) : r_q - DIGIT_W'(1);
    end
  end

  // Digit register with synchronous active-low reset.
  always_ff @(posedge CK) begin
    if (!RN) r_q <= '0;
    else     r_q <= w_next;
  end

  assign o_q      = r_q;
  assign o_q_next = w_next;

endmodule

// File: rtl/seg_counter_cmp.sv
// Programmable up/down counter built from cascaded digit stages, with load,
// modulus wrap, registered terminal-count pulse and registered masked compare.
module seg_counter_cmp
  import seg_counter_pkg::*;
#(
  parameter int unsigned DIGIT_W    = 4,
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned W          = calc_w(DIGIT_W, NUM_DIGITS)
) (
  input  logic         CK,
  input  logic         RN,
  input  logic         EN,
  input  logic         UP,
  input  logic         LD,
  input  logic [W-1:0] LD_VAL,
  input  logic         MOD_EN,
  input  logic [W-1:0] MOD_VAL,
  input  logic [W-1:0] CMP_VAL,
  input  logic [W-1:0] CMP_MASK,
  output logic [W-1:0] Q,
  output logic         TC,
  output logic         Z
);

  logic [NUM_DIGITS:0] w_carry;
  logic [W-1:0]        w_q;
  logic [W-1:0]        w_qn;
  logic [W-1:0]        w_force_val;
  dir_e                w_dir;
  logic                w_mod_hit;
  logic                w_wrap;
  logic                w_force;
  logic                r_tc;
  logic                r_z;

  assign w_carry[0] = EN;

  // The carry out of the top digit is exactly the natural 2^W wrap (all-ones
  // going up, zero going down); the modulus hit is added on top of it, and
  // every wrap forces all digits to the wrap target in one step.
  always_comb begin
    w_dir       = dir_e'(UP);
    w_mod_hit   = (w_dir == DIR_UP) & MOD_EN & (w_q == MOD_VAL);
    w_wrap      = w_carry[NUM_DIGITS] | (EN & w_mod_hit);
    w_force     = ~LD & w_wrap;
    w_force_val = '0;
    if (w_dir == DIR_DOWN) w_force_val = MOD_EN ? MOD_VAL : '1;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seg_digit #(
      .DIGIT_W(DIGIT_W)
    ) u_digit (
      .CK         (CK),
      .RN         (RN),
      .i_cen      (w_carry[g]),
      .i_dir      (w_dir),
      .i_ld       (LD),
      .i_ld_val   (LD_VAL[g*DIGIT_W +: DIGIT_W]),
      .i_force    (w_force),
      .i_force_val(w_force_val[g*DIGIT_W +: DIGIT_W]),
      .o_q        (w_q[g*DIGIT_W +: DIGIT_W]),
      .o_q_next   (w_qn[g*DIGIT_W +: DIGIT_W]),
      .o_cout     (w_carry[g+1])
    );
  end

  // Terminal-count pulse and compare flag, both computed from the value Q
  // takes at this edge so they line up with Q.
  always_ff @(posedge CK) begin
    if (!RN) begin
      r_tc <= 1'b0;
      r_z  <= 1'b0;
    end else begin
      r_tc <= w_force;
      r_z  <= masked_eq(MAX_W'(w_qn), MAX_W'(CMP_VAL), MAX_W'(CMP_MASK));
    end
  end

  assign Q  = w_q;
  assign TC = r_tc;
  assign Z  = r_z;

endmodule

// File: tb/tb_seg_counter_cmp.sv
// Self-checking bench for seg_counter_cmp: directed scenarios plus a random
// phase, all compared against an arithmetic reference model.
module tb_seg_counter_cmp;

  localparam int unsigned W = 16;

  logic         CK = 1'b0;
  logic         RN, EN, UP, LD, MOD_EN;
  logic [W-1:0] LD_VAL, MOD_VAL, CMP_VAL, CMP_MASK;
  logic [W-1:0] Q;
  logic         TC, Z;

  logic [W-1:0] mq;
  logic         mtc, mz;
  int           errors = 0;
  int           checks = 0;

  seg_counter_cmp #(
    .DIGIT_W   (4),
    .NUM_DIGITS(4)
  ) dut (
    .CK(CK), .RN(RN), .EN(EN), .UP(UP), .LD(LD), .LD_VAL(LD_VAL),
    .MOD_EN(MOD_EN), .MOD_VAL(MOD_VAL), .CMP_VAL(CMP_VAL),
    .CMP_MASK(CMP_MASK), .Q(Q), .TC(TC), .Z(Z)
  );

  always #5 CK = ~CK;

  // Reference model: the counting rules stated directly in integer terms.
  task automatic model_update();
    if (!RN) begin
      mq = '0; mtc = 1'b0; mz = 1'b0;
    end else begin
      if (LD) begin
        mq = LD_VAL; mtc = 1'b0;
      end else if (EN && UP) begin
        if ((MOD_EN && mq == MOD_VAL) || mq == 16'hFFFF) begin
          mq = '0; mtc = 1'b1;
        end else begin
          mq = mq + 16'd1; mtc = 1'b0;
        end
      end else if (EN) begin
        if (mq == 0) begin
          mq = MOD_EN ? MOD_VAL : 16'hFFFF; mtc = 1'b1;
        end else begin
          mq = mq - 16'd1; mtc = 1'b0;
        end
      end else begin
        mtc = 1'b0;
      end
      mz = ((mq ^ CMP_VAL) & CMP_MASK) == 0;
    end
  endtask

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: advance the model on the edge, then compare all outputs.
  task automatic step();
    @(posedge CK);
    model_update();
    #1;
    chk("Q", Q, mq);
    chk("TC", {15'd0, TC}, {15'd0, mtc});
    chk("Z", {15'd0, Z}, {15'd0, mz});
  endtask

  initial begin
    mq = '0; mtc = 1'b0; mz = 1'b0;
    RN = 1'b0; EN = 1'b1; UP = 1'b1; LD = 1'b1; LD_VAL = 16'h5A5A;
    MOD_EN = 1'b0; MOD_VAL = '0; CMP_VAL = '0; CMP_MASK = '0;

    // Reset overrides load and count; Z stays 0 even though mask=0 would match.
    step(); step();
    chk("reset_Q", Q, 16'h0000);
    chk("reset_TC", {15'd0, TC}, 16'd0);
    chk("reset_Z", {15'd0, Z}, 16'd0);
    RN = 1'b1; LD = 1'b0;
    step();
    chk("first_count", Q, 16'h0001);
    chk("mask0_Z", {15'd0, Z}, 16'd1);

    // Digit carry across three digits, then full-width wrap.
    LD = 1'b1; LD_VAL = 16'h0FFF; step();
    LD = 1'b0; step();
    chk("carry_Q", Q, 16'h1000);
    chk("carry_TC", {15'd0, TC}, 16'd0);
    LD = 1'b1; LD_VAL = 16'hFFFF; step();
    LD = 1'b0; step();
    chk("wrap_Q", Q, 16'h0000);
    chk("wrap_TC", {15'd0, TC}, 16'd1);
    step();
    chk("wrap_TC_pulse", {15'd0, TC}, 16'd0);

    // Modulus-10 up count.
    MOD_EN = 1'b1; MOD_VAL = 16'd9; LD = 1'b1; LD_VAL = 16'd0; step();
    LD = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      step();
      chk("mod_up_Q", Q, 16'(k % 10));
      chk("mod_up_TC", {15'd0, TC}, {15'd0, (k == 10 || k == 20)});
    end

    // Modulus down with MOD_VAL changed mid-run.
    MOD_VAL = 16'd5; LD = 1'b1; LD_VAL = 16'd0; step();
    LD = 1'b0; UP = 1'b0; step();
    chk("mod_dn_Q", Q, 16'd5);
    chk("mod_dn_TC", {15'd0, TC}, 16'd1);
    step(); step(); step();
    chk("mod_dn_Q2", Q, 16'd2);
    MOD_VAL = 16'd3;
    step(); step(); step();
    chk("mod_dn_Q3", Q, 16'd3);
    chk("mod_dn_TC3", {15'd0, TC}, 16'd1);

    // Load beats count in the same cycle; then hold with EN=0.
    LD = 1'b1; EN = 1'b1; LD_VAL = 16'h1234; step();
    chk("ld_prio_Q", Q, 16'h1234);
    chk("ld_prio_TC", {15'd0, TC}, 16'd0);
    LD = 1'b0; EN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_Q", Q, 16'h1234);
    end

    // Masked compare window while counting up.
    MOD_EN = 1'b0; UP = 1'b1; CMP_VAL = 16'h00A0; CMP_MASK = 16'h00F0;
    LD = 1'b1; LD_VAL = 16'h009E; step();
    chk("cmp_start_Z", {15'd0, Z}, 16'd0);
    LD = 1'b0; EN = 1'b1;
    for (int k = 0; k < 19; k++) begin
      step();
      chk("cmp_Z", {15'd0, Z}, {15'd0, (Q >= 16'h00A0 && Q <= 16'h00AF)});
    end
    chk("cmp_end_Q", Q, 16'h00B1);

    // Back-to-back wraps with MOD_VAL=0.
    MOD_EN = 1'b1; MOD_VAL = 16'd0; LD = 1'b1; LD_VAL = 16'd0; step();
    LD = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("b2b_TC", {15'd0, TC}, 16'd1);
    end

    // Out-of-range count runs up to all-ones before wrapping.
    MOD_VAL = 16'd5; LD = 1'b1; LD_VAL = 16'hFFFE; step();
    LD = 1'b0; step();
    chk("oor_Q", Q, 16'hFFFF);
    step();
    chk("oor_wrap_Q", Q, 16'h0000);
    chk("oor_wrap_TC", {15'd0, TC}, 16'd1);

    // Random phase.
    for (int n = 0; n < 400; n++) begin
      RN = ($urandom_range(0, 49) != 0);
      LD = ($urandom_range(0, 15) == 0);
      EN = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) UP = ~UP;
      if ($urandom_range(0, 31) == 0) MOD_EN = ~MOD_EN;
      if ($urandom_range(0, 15) == 0)
        MOD_VAL = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      case ($urandom_range(0, 3))
        0:       LD_VAL = 16'hFFFF - 16'($urandom_range(0, 3));
        1:       LD_VAL = 16'($urandom_range(0, 3));
        default: LD_VAL = 16'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) begin
        CMP_VAL  = 16'($urandom);
        CMP_MASK = 16'($urandom & $urandom & $urandom);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
